// File: rtl/four_req_rr_bus_arbiter.sv
//------------------------------------------------------------------------------
// Module   : four_req_rr_bus_arbiter
// Brief    : Round-robin owner arbiter for a 4-to-1 tri-state bus mux, with a
//            one-cycle dead turn between owners and a per-grant hold timeout.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module four_req_rr_bus_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] S,
    output logic       E,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_last;
    logic [CNT_W-1:0] r_cnt;

    logic             w_win_valid;
    logic [1:0]       w_win;
    logic [1:0]       w_idx;
    logic             w_release;
    logic             w_expired;

    // Scan from farthest to nearest so the nearest set bit after r_last wins.
    always_comb begin
        w_win_valid = |req;
        w_win       = r_last;
        w_idx       = r_last;
        for (int k = 4; k >= 1; k--) begin
            w_idx = r_last + 2'(k);
            if (req[w_idx]) begin
                w_win = w_idx;
            end
        end
    end

    assign w_release = done | ~req[S];
    assign w_expired = (r_cnt == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_last  <= 2'd3;
            r_cnt   <= '0;
            S       <= 2'd0;
            E       <= 1'b0;
            gnt     <= 4'b0000;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (r_state)
                ST_GRANT: begin
                    if (w_release || w_expired) begin
                        r_state <= ST_TURN;
                        r_last  <= S;
                        r_cnt   <= '0;
                        E       <= 1'b0;
                        gnt     <= 4'b0000;
                        busy    <= 1'b1;
                        // A release in the same cycle as expiry is not a timeout.
                        timeout <= w_expired & ~w_release;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (w_win_valid) begin
                        r_state <= ST_GRANT;
                        r_cnt   <= '0;
                        S       <= w_win;
                        E       <= 1'b1;
                        gnt     <= 4'b0001 << w_win;
                        busy    <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        E       <= 1'b0;
                        gnt     <= 4'b0000;
                        busy    <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_four_req_rr_bus_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_four_req_rr_bus_arbiter
// Brief    : Scoreboard bench: expected grants are queued by the stimulus and
//            checked by a monitor each time a grant ends.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_four_req_rr_bus_arbiter;

    localparam int c_MAX_HOLD = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [1:0] S;
    logic       E;
    logic [3:0] gnt;
    logic       busy;
    logic       timeout;

    typedef struct packed {
        logic [1:0] s;
        logic [7:0] len;
        logic       to;
    } grant_t;

    grant_t exp_q[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     grants_done = 0;
    logic   mon_en = 1'b0;

    four_req_rr_bus_arbiter #(.MAX_HOLD(c_MAX_HOLD), .CNT_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .S       (S),
        .E       (E),
        .gnt     (gnt),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: per-cycle invariants plus grant tracking against the scoreboard.
    logic [1:0] cur_s;
    int         cur_len;
    logic       prev_e = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
            check("gnt_vs_E_S", 32'(gnt), E ? 32'(4'b0001 << S) : 32'd0);
            if (E && !prev_e) begin
                cur_s   = S;
                cur_len = 1;
            end else if (E && prev_e) begin
                check("S_stable_while_E", 32'(S), 32'(cur_s));
                cur_len++;
            end else if (!E && prev_e) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_grant: S=%0d len=%0d", cur_s, cur_len);
                end else begin
                    grant_t g;
                    g = exp_q.pop_front();
                    check("grant_S", 32'(cur_s), 32'(g.s));
                    check("grant_len", 32'(cur_len), 32'(g.len));
                    check("grant_timeout", 32'(timeout), 32'(g.to));
                end
                grants_done++;
            end
            prev_e = E;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_e_high(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            step();
            if (E) break;
        end
        if (i == budget) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_E_high: E stayed %0b after %0d cycles", E, budget);
        end
    endtask

    task automatic wait_grants(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (grants_done >= target) break;
            step();
        end
        if (grants_done < target) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_grants: got %0d grants expected %0d", grants_done, target);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        step();
        step();
        mon_en = 1'b1;
        check("rst_S", 32'(S), 32'd0);
        check("rst_E", 32'(E), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        step();

        // All four request continuously: rotation 0,1,2,3,0 with full timeouts.
        exp_q.push_back('{s: 2'd0, len: 8'd8, to: 1'b1});
        exp_q.push_back('{s: 2'd1, len: 8'd8, to: 1'b1});
        exp_q.push_back('{s: 2'd2, len: 8'd8, to: 1'b1});
        exp_q.push_back('{s: 2'd3, len: 8'd8, to: 1'b1});
        exp_q.push_back('{s: 2'd0, len: 8'd8, to: 1'b1});
        req = 4'b1111;
        wait_grants(5, 100);
        req = 4'b0000;
        step();
        check("idle_busy", 32'(busy), 32'd0);
        step();

        // Sole requester releases with done on its 3rd cycle, then is re-granted.
        exp_q.push_back('{s: 2'd2, len: 8'd3, to: 1'b0});
        exp_q.push_back('{s: 2'd2, len: 8'd8, to: 1'b1});
        req = 4'b0100;
        wait_e_high(10);
        step();
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        check("turn_busy", 32'(busy), 32'd1);
        check("turn_E", 32'(E), 32'd0);
        wait_grants(7, 50);
        req = 4'b0000;
        step();
        step();

        // Owner 1 loses its request mid-grant; round-robin moves on to 3.
        exp_q.push_back('{s: 2'd1, len: 8'd3, to: 1'b0});
        exp_q.push_back('{s: 2'd3, len: 8'd8, to: 1'b1});
        req = 4'b0010;
        wait_e_high(10);
        step();
        req = 4'b1010;
        step();
        req = 4'b1000;
        wait_grants(9, 50);
        req = 4'b0000;
        step();
        step();

        // Reset lands during a grant of source 2; source 0 then wins first.
        exp_q.push_back('{s: 2'd2, len: 8'd3, to: 1'b0});
        exp_q.push_back('{s: 2'd0, len: 8'd8, to: 1'b1});
        exp_q.push_back('{s: 2'd2, len: 8'd8, to: 1'b1});
        req = 4'b0100;
        wait_e_high(10);
        step();
        step();
        rst_n = 1'b0;
        req   = 4'b0101;
        step();
        check("midrst_S", 32'(S), 32'd0);
        check("midrst_E", 32'(E), 32'd0);
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        wait_grants(12, 60);
        req = 4'b0000;
        step();
        step();
        step();
        check("final_E", 32'(E), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
